lf_square_gen: RTL

//  Programmable low-frequency square-wave generator; stimulus end of the LF measurement path.

---
 rtl/lf_square_gen_pkg.sv | 37 +++
 rtl/lf_square_gen_if.sv | 19 +
 rtl/lf_tick_gen.sv | 65 ++++++
 rtl/lf_square_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lf_square_gen_pkg.sv
// Shared types and constants for the LF square-wave generator: FSM states,
// digit field layout and the half-period dividend table.
package lf_square_gen_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned N_W   = 14;
  localparam int unsigned POW_W = 32;

  // One display digit: decimal point to the right of the digit plus its BCD value.
  typedef struct packed {
    logic             dp;
    logic [BCD_W-1:0] bcd;
  } dig_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SCALE,
    ST_DIV,
    ST_LOAD
  } state_t;

  // 500000 * 10^k: half a second in microseconds, scaled by the fraction digits.
  function automatic logic [POW_W-1:0] pow10_half(input logic [1:0] k);
    logic [POW_W-1:0] r;
    r = 32'd500000;
    case (k)
      2'd0: r = 32'd500000;
      2'd1: r = 32'd5000000;
      2'd2: r = 32'd50000000;
      2'd3: r = 32'd500000000;
      default: r = 32'd500000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lf_square_gen_if.sv
// Setting/handshake bundle between a controller and lf_square_gen.
interface lf_square_gen_if;
  import lf_square_gen_pkg::*;

  logic start;
  dig_t dig3;
  dig_t dig2;
  dig_t dig1;
  dig_t dig0;
  logic ready;
  logic done_tick;
  logic err;
  logic so;

  modport master (output start, dig3, dig2, dig1, dig0,
                  input  ready, done_tick, err, so);
  modport slave  (input  start, dig3, dig2, dig1, dig0,
                  output ready, done_tick, err, so);
endinterface

// File: rtl/lf_tick_gen.sv
// Microsecond prescaler, half-period counter and so toggle with double-buffered hp.
// LF_GEN_PHASE_RESET_EN: a load restarts the waveform immediately, phase-aligned.
module lf_tick_gen #(
  parameter int unsigned CLK_DIV = 100,
  parameter int unsigned HP_W    = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [HP_W-1:0] load_val,
  output logic            so
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);

  logic             en;
  logic [PRE_W-1:0] pre;
  logic [HP_W-1:0]  hc;
  logic [HP_W-1:0]  hp;
  logic [HP_W-1:0]  hp_next;
  logic             us_tick_c;

  assign us_tick_c = en && (pre == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      pre     <= '0;
      hc      <= '0;
      hp      <= '0;
      hp_next <= '0;
      so      <= 1'b0;
    end else begin
      if (en) pre <= us_tick_c ? '0 : pre + PRE_W'(1);
      if (us_tick_c) begin
        if (hc == hp - HP_W'(1)) begin
          hc <= '0;
          so <= ~so;
          // A load landing on the toggle cycle must not be lost.
          hp <= load ? load_val : hp_next;
        end else begin
          hc <= hc + HP_W'(1);
        end
      end
      if (load) begin
        hp_next <= load_val;
`ifdef LF_GEN_PHASE_RESET_EN
        en  <= 1'b1;
        hp  <= load_val;
        pre <= '0;
        hc  <= '0;
        so  <= 1'b0;
`else
        if (!en) begin
          en  <= 1'b1;
          hp  <= load_val;
          pre <= '0;
          hc  <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/lf_square_gen.sv
// LF square-wave generator: decimal setting -> BCD->binary -> 500000*10^k / N half-period.
// Optional LF_GEN_PHASE_RESET_EN makes each load restart the waveform immediately.
module lf_square_gen
  import lf_square_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100,
  parameter int unsigned HP_W    = 30
) (
  input  logic           clk,
  input  logic           reset,
  lf_square_gen_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(HP_W);

  state_t                  state;
  logic [3:0][BCD_W-1:0]   bcd_q;
  logic [1:0]              k_q;
  logic                    bad_q;
  logic [N_W-1:0]          n_q;
  logic [N_W-1:0]          rem_q;
  logic [HP_W-1:0]         quo_q;
  logic [CNT_W-1:0]        cnt;
  logic                    ready_q;
  logic                    done_q;
  logic                    err_q;
  logic                    so;

  logic [2:0]              dp_cnt_c;
  logic                    in_bad_c;
  logic [1:0]              in_k_c;
  logic [N_W:0]            rem_sh_c;
  logic [N_W-1:0]          rem_sub_c;
  logic                    quo_bit_c;
  logic                    load_c;

  // Setting validity and fraction-digit count, evaluated on the incoming digits.
  always_comb begin
    dp_cnt_c = 3'(bus.dig3.dp) + 3'(bus.dig2.dp) + 3'(bus.dig1.dp) + 3'(bus.dig0.dp);
    in_bad_c = (bus.dig3.bcd > 4'd9) || (bus.dig2.bcd > 4'd9) ||
               (bus.dig1.bcd > 4'd9) || (bus.dig0.bcd > 4'd9) ||
               (dp_cnt_c > 3'd1) ||
               ({bus.dig3.bcd, bus.dig2.bcd, bus.dig1.bcd, bus.dig0.bcd} == 16'd0);
    in_k_c = 2'd0;
    if (bus.dig3.dp)      in_k_c = 2'd3;
    else if (bus.dig2.dp) in_k_c = 2'd2;
    else if (bus.dig1.dp) in_k_c = 2'd1;
  end

  // One restoring-division step; the dividend shifts out of quo_q as quotient bits shift in.
  always_comb begin
    rem_sh_c  = {rem_q, quo_q[HP_W-1]};
    quo_bit_c = rem_sh_c >= {1'b0, n_q};
    rem_sub_c = N_W'(rem_sh_c - {1'b0, n_q});
  end

  assign load_c = (state == ST_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bcd_q   <= '0;
      k_q     <= '0;
      bad_q   <= 1'b0;
      n_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bcd_q   <= {bus.dig3.bcd, bus.dig2.bcd, bus.dig1.bcd, bus.dig0.bcd};
            k_q     <= in_k_c;
            bad_q   <= in_bad_c;
            err_q   <= 1'b0;
            n_q     <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          n_q   <= N_W'(n_q * N_W'(10) + N_W'(bcd_q[3]));
          bcd_q <= {bcd_q[2:0], 4'd0};
          if (cnt == CNT_W'(3)) begin
            err_q  <= bad_q;
            done_q <= bad_q;
            state  <= ST_SCALE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SCALE: begin
          if (bad_q) begin
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            quo_q <= HP_W'(pow10_half(k_q));
            rem_q <= '0;
            cnt   <= '0;
            state <= ST_DIV;
          end
        end
        ST_DIV: begin
          rem_q <= quo_bit_c ? rem_sub_c : rem_sh_c[N_W-1:0];
          quo_q <= {quo_q[HP_W-2:0], quo_bit_c};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(HP_W - 1)) begin
            done_q <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  lf_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .HP_W    (HP_W)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (load_c),
    .load_val (quo_q),
    .so       (so)
  );

  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;
  assign bus.err       = err_q;
  assign bus.so        = so;

endmodule
